// File: rtl/cpu7_lsu.sv
// Load/store unit between the EX/MEM register and the data bus: byte-enable
// generation, store rotation, load extraction/extension and misaligned split.
//
// state  | meaning
// IDLE   | ready for a request
// REQ0   | first bus beat offered, waiting for bus_ready
// WAIT0  | first beat accepted, waiting for bus_rvalid
// REQ1   | second beat of a line-crossing access offered
// WAIT1  | second beat accepted, waiting for bus_rvalid
// RESP   | one-cycle response to writeback
module cpu7_lsu #(
    parameter int XLEN             = 32,
    parameter bit SPLIT_MISALIGNED = 1'b1,
    parameter int RFIDX_W          = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_we,
    input  logic [XLEN-1:0]    req_addr,
    input  logic [XLEN-1:0]    req_wdata,
    input  logic [1:0]         req_width,
    input  logic               req_signext,
    input  logic [RFIDX_W-1:0] req_rd,
    output logic               rsp_valid,
    output logic [XLEN-1:0]    rsp_rdata,
    output logic [RFIDX_W-1:0] rsp_rd,
    output logic               rsp_err,
    output logic               bus_valid,
    input  logic               bus_ready,
    output logic               bus_we,
    output logic [XLEN-1:0]    bus_addr,
    output logic [XLEN-1:0]    bus_wdata,
    output logic [XLEN/8-1:0]  bus_be,
    input  logic               bus_rvalid,
    input  logic [XLEN-1:0]    bus_rdata
);

    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);
    localparam logic [XLEN-1:0] WORD_STEP = XLEN'(NB);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ0,
        S_WAIT0,
        S_REQ1,
        S_WAIT1,
        S_RESP
    } state_t;

    state_t state;

    logic               we_q;
    logic [OFFW-1:0]    off_q;
    logic [1:0]         width_q;
    logic               signext_q;
    logic [RFIDX_W-1:0] rd_q;
    logic [XLEN-1:0]    base_q;
    logic [XLEN-1:0]    wdata_q;
    logic [NB-1:0]      be1_q;
    logic               cross_q;
    logic [XLEN-1:0]    beat0;

    logic [OFFW-1:0]    req_off;
    logic [3:0]         req_size;
    logic [2*NB-1:0]    req_mask;
    logic               req_cross;
    logic               req_err;
    logic [XLEN-1:0]    req_base;
    logic [XLEN-1:0]    req_rot;

    // Request decode: byte mask spans two words so the upper half is beat 1.
    always_comb begin
        req_off  = req_addr[OFFW-1:0];
        req_size = 4'd1 << req_width;
        req_base = {req_addr[XLEN-1:OFFW], {OFFW{1'b0}}};
        req_rot  = XLEN'({req_wdata, req_wdata} >> (XLEN - 8 * int'(req_off)));
        req_mask = '0;
        for (int j = 0; j < 2 * NB; j++) begin
            req_mask[j] = (j >= int'(req_off)) && (j < int'(req_off) + int'(req_size));
        end
        req_cross = |req_mask[2*NB-1:NB];
        req_err   = ((req_width == 2'd3) && (XLEN == 32)) ||
                    (req_cross && !SPLIT_MISALIGNED);
    end

    logic [XLEN-1:0] asm_b0;
    logic [XLEN-1:0] asm_b1;
    logic [XLEN-1:0] raw;
    logic [XLEN-1:0] load_val;
    logic            sfill;
    int              nbits;

    // Load assembly uses the live bus word for the final beat.
    always_comb begin
        asm_b0 = (state == S_WAIT1) ? beat0 : bus_rdata;
        asm_b1 = (state == S_WAIT1) ? bus_rdata : '0;
        raw    = XLEN'({asm_b1, asm_b0} >> {off_q, 3'b000});
        nbits  = 8 << width_q;
        case (width_q)
            2'd0:    sfill = raw[7];
            2'd1:    sfill = raw[15];
            2'd2:    sfill = raw[31];
            default: sfill = raw[XLEN-1];
        endcase
        sfill    = sfill & signext_q;
        load_val = '0;
        for (int i = 0; i < XLEN; i++) begin
            load_val[i] = (i < nbits) ? raw[i] : sfill;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_rd    <= '0;
            rsp_err   <= 1'b0;
            bus_valid <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_be    <= '0;
            we_q      <= 1'b0;
            off_q     <= '0;
            width_q   <= '0;
            signext_q <= 1'b0;
            rd_q      <= '0;
            base_q    <= '0;
            wdata_q   <= '0;
            be1_q     <= '0;
            cross_q   <= 1'b0;
            beat0     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        we_q      <= req_we;
                        off_q     <= req_off;
                        width_q   <= req_width;
                        signext_q <= req_signext;
                        rd_q      <= req_rd;
                        base_q    <= req_base;
                        wdata_q   <= req_rot;
                        be1_q     <= req_mask[2*NB-1:NB];
                        cross_q   <= req_cross;
                        beat0     <= '0;
                        if (req_err) begin
                            state     <= S_RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rd    <= req_rd;
                            rsp_rdata <= '0;
                        end else begin
                            state     <= S_REQ0;
                            bus_valid <= 1'b1;
                            bus_we    <= req_we;
                            bus_addr  <= req_base;
                            bus_wdata <= req_rot;
                            bus_be    <= req_mask[NB-1:0];
                        end
                    end
                end
                S_REQ0, S_REQ1: begin
                    if (bus_ready) begin
                        state     <= (state == S_REQ0) ? S_WAIT0 : S_WAIT1;
                        bus_valid <= 1'b0;
                        bus_we    <= 1'b0;
                        bus_addr  <= '0;
                        bus_wdata <= '0;
                        bus_be    <= '0;
                    end
                end
                S_WAIT0: begin
                    if (bus_rvalid) begin
                        beat0 <= bus_rdata;
                        if (cross_q) begin
                            state     <= S_REQ1;
                            bus_valid <= 1'b1;
                            bus_we    <= we_q;
                            bus_addr  <= base_q + WORD_STEP;
                            bus_wdata <= wdata_q;
                            bus_be    <= be1_q;
                        end else begin
                            state     <= S_RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b0;
                            rsp_rd    <= rd_q;
                            rsp_rdata <= we_q ? '0 : load_val;
                        end
                    end
                end
                S_WAIT1: begin
                    if (bus_rvalid) begin
                        state     <= S_RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rd    <= rd_q;
                        rsp_rdata <= we_q ? '0 : load_val;
                    end
                end
                S_RESP: begin
                    state     <= S_IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                    rsp_rd    <= '0;
                    rsp_rdata <= '0;
                end
                default: begin
                    state     <= S_IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu7_lsu.sv
// Bench for cpu7_lsu: directed cases plus random loads/stores against a
// byte-addressed memory model with a randomly stalling bus responder.
module tb_cpu7_lsu;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    int          cyc = 0;

    logic        req_valid = 1'b0, req_we = 1'b0, req_signext = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [1:0]  req_width = '0;
    logic [4:0]  req_rd = '0;
    logic        req_ready, rsp_valid, rsp_err, bus_valid, bus_we;
    logic [31:0] rsp_rdata, bus_addr, bus_wdata;
    logic [4:0]  rsp_rd;
    logic [3:0]  bus_be;
    logic        bus_ready = 1'b0, bus_rvalid = 1'b0;
    logic [31:0] bus_rdata = '0;

    logic        ns_req_valid = 1'b0;
    logic [31:0] ns_req_addr = '0;
    logic [1:0]  ns_req_width = '0;
    logic [4:0]  ns_req_rd = '0;
    logic        ns_req_ready, ns_rsp_valid, ns_rsp_err, ns_bus_valid, ns_bus_we;
    logic [31:0] ns_rsp_rdata, ns_bus_addr, ns_bus_wdata;
    logic [4:0]  ns_rsp_rd;
    logic [3:0]  ns_bus_be;
    logic        ns_zero = 1'b0;
    logic [31:0] ns_zero_w = '0;

    cpu7_lsu #(.XLEN(32), .SPLIT_MISALIGNED(1'b1), .RFIDX_W(5)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_width(req_width),
        .req_signext(req_signext), .req_rd(req_rd),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_rd(rsp_rd), .rsp_err(rsp_err),
        .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_be(bus_be),
        .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
    );

    cpu7_lsu #(.XLEN(32), .SPLIT_MISALIGNED(1'b0), .RFIDX_W(5)) dut_ns (
        .clk(clk), .reset(reset),
        .req_valid(ns_req_valid), .req_ready(ns_req_ready), .req_we(ns_zero),
        .req_addr(ns_req_addr), .req_wdata(ns_zero_w), .req_width(ns_req_width),
        .req_signext(ns_zero), .req_rd(ns_req_rd),
        .rsp_valid(ns_rsp_valid), .rsp_rdata(ns_rsp_rdata), .rsp_rd(ns_rsp_rd),
        .rsp_err(ns_rsp_err),
        .bus_valid(ns_bus_valid), .bus_ready(ns_zero), .bus_we(ns_bus_we),
        .bus_addr(ns_bus_addr), .bus_wdata(ns_bus_wdata), .bus_be(ns_bus_be),
        .bus_rvalid(ns_zero), .bus_rdata(ns_zero_w)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Memory seen by the bus (written by the DUT) and the reference memory.
    logic [7:0] mem [logic [31:0]];
    logic [7:0] ref_mem [logic [31:0]];

    function automatic logic [7:0] dflt(input logic [31:0] a);
        return 8'(a * 7 + 3);
    endfunction

    function automatic logic [7:0] rd_mem(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return dflt(a);
    endfunction

    function automatic logic [7:0] rd_ref(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return dflt(a);
    endfunction

    task automatic set_word(input logic [31:0] a, input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            mem[a + 32'(i)]     = w[8*i +: 8];
            ref_mem[a + 32'(i)] = w[8*i +: 8];
        end
    endtask

    function automatic logic [31:0] model_load(input logic [31:0] a, input int size, input logic sx);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < size; i++) v = v | (64'(rd_ref(a + 32'(i))) << (8 * i));
        if (sx && v[8*size-1]) begin
            for (int i = 8 * size; i < 32; i++) v[i] = 1'b1;
        end
        return v[31:0];
    endfunction

    // Bus responder
    int          r_delay = 0, v_delay = 1, pend = 0, stall = 0, unstable = 0;
    bit          seen = 0;
    logic [31:0] pend_data = '0, s_addr = '0, s_wdata = '0;
    logic [3:0]  s_be = '0;
    logic        s_we = 1'b0;
    logic [31:0] log_addr[$], log_wdata[$];
    logic [3:0]  log_be[$];
    logic        log_we[$];

    initial begin
        forever begin
            @(negedge clk);
            bus_rvalid = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    bus_rvalid = 1'b1;
                    bus_rdata  = pend_data;
                end
            end
            bus_ready = 1'b0;
            if (reset) seen = 0;
            if (bus_valid === 1'b1) begin
                if (!seen) begin
                    seen = 1; stall = 0;
                    s_addr = bus_addr; s_wdata = bus_wdata; s_be = bus_be; s_we = bus_we;
                end else if ({bus_addr, bus_wdata, bus_be, bus_we} !== {s_addr, s_wdata, s_be, s_we}) begin
                    unstable++;
                end
                if (stall < r_delay) begin
                    stall++;
                end else begin
                    bus_ready = 1'b1;
                    seen = 0;
                    log_addr.push_back(bus_addr);
                    log_wdata.push_back(bus_wdata);
                    log_be.push_back(bus_be);
                    log_we.push_back(bus_we);
                    pend_data = '0;
                    for (int b = 0; b < 4; b++) begin
                        if (bus_we && bus_be[b]) mem[bus_addr + 32'(b)] = bus_wdata[8*b +: 8];
                        else pend_data[8*b +: 8] = rd_mem(bus_addr + 32'(b));
                    end
                    pend = v_delay;
                end
            end
        end
    end

    task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [1:0] width, input logic sx, input logic [4:0] rd,
                           input int rdel, input int vdel, output logic [31:0] got_rdata);
        int size, beats, exp_lat, acc, lat;
        bit err, got;
        logic [31:0] exp_rdata, wa, diff;
        logic [3:0] exp_be;
        size      = 1 << width;
        err       = (width == 2'd3);
        beats     = err ? 0 : ((int'(addr[1:0]) + size > 4) ? 2 : 1);
        exp_rdata = (err || we) ? 32'h0 : model_load(addr, size, sx);
        exp_lat   = err ? 1 : 1 + beats * (1 + rdel + vdel);
        r_delay = rdel; v_delay = vdel; unstable = 0;
        log_addr.delete(); log_wdata.delete(); log_be.delete(); log_we.delete();
        @(negedge clk);
        chk("ready_idle", req_ready, 1);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
        req_width = width; req_signext = sx; req_rd = rd;
        acc = cyc; got = 0;
        for (int k = 0; k < 300 && !got; k++) begin
            @(negedge clk);
            if (k == 0) req_valid = 1'b0;
            if (rsp_valid === 1'b1) got = 1;
        end
        lat = cyc - acc;
        chk("rsp_seen", got, 1);
        chk("latency", lat, exp_lat);
        chk("rsp_err", rsp_err, err);
        chk("rsp_rd", rsp_rd, rd);
        chk("rsp_rdata", rsp_rdata, exp_rdata);
        got_rdata = rsp_rdata;
        chk("beats", log_addr.size(), beats);
        chk("bus_stable", unstable, 0);
        for (int b = 0; b < log_addr.size() && b < 2; b++) begin
            wa = (addr & ~32'h3) + 32'(4 * b);
            exp_be = '0;
            for (int bt = 0; bt < 4; bt++) begin
                diff = wa + 32'(bt) - addr;
                if (diff < 32'(size)) exp_be[bt] = 1'b1;
            end
            chk("beat_addr", log_addr[b], wa);
            chk("beat_be", log_be[b], exp_be);
            chk("beat_we", log_we[b], we);
        end
        if (we && !err) begin
            for (int i = 0; i < size; i++) ref_mem[addr + 32'(i)] = wdata[8*i +: 8];
        end
        for (int i = -1; i <= size; i++) chk("mem_byte", rd_mem(addr + 32'(i)), rd_ref(addr + 32'(i)));
        @(negedge clk);
        chk("rsp_pulse", rsp_valid, 0);
        chk("rsp_clear", {rsp_rdata, rsp_rd, rsp_err}, 0);
        chk("ready_back", req_ready, 1);
    endtask

    initial begin
        logic [31:0] r, a, wd;
        logic [1:0]  w;
        int          hits;

        repeat (3) @(negedge clk);
        chk("rst_ready", req_ready, 1);
        chk("rst_rsp", {rsp_valid, rsp_rdata, rsp_rd, rsp_err}, 0);
        chk("rst_bus", {bus_valid, bus_we, bus_addr, bus_wdata, bus_be}, 0);
        chk("rst_ns_ready", ns_req_ready, 1);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_bus", bus_valid, 0);

        set_word(32'h100, 32'hDEADBEEF);
        run_txn(1'b0, 32'h100, 32'h0, 2'd2, 1'b0, 5'd7, 0, 1, r);
        chk("lw_data", r, 32'hDEADBEEF);
        chk("lw_addr", log_addr[0], 32'h100);
        chk("lw_be", log_be[0], 4'hF);

        set_word(32'h100, 32'h80112233);
        run_txn(1'b0, 32'h103, 32'h0, 2'd0, 1'b1, 5'd3, 0, 1, r);
        chk("lb_data", r, 32'hFFFFFF80);
        chk("lb_be", log_be[0], 4'h8);
        run_txn(1'b0, 32'h103, 32'h0, 2'd0, 1'b0, 5'd4, 1, 2, r);
        chk("lbu_data", r, 32'h00000080);

        run_txn(1'b1, 32'h102, 32'h1234ABCD, 2'd1, 1'b0, 5'd9, 3, 1, r);
        chk("sh_rdata", r, 32'h0);
        chk("sh_addr", log_addr[0], 32'h100);
        chk("sh_be", log_be[0], 4'hC);
        chk("sh_wdata", log_wdata[0], 32'hABCD1234);

        set_word(32'h0FC, 32'h55661122);
        set_word(32'h100, 32'h00003344);
        run_txn(1'b0, 32'h0FE, 32'h0, 2'd2, 1'b0, 5'd11, 0, 1, r);
        chk("split_data", r, 32'h33445566);
        chk("split_be0", log_be[0], 4'hC);
        chk("split_addr1", log_addr[1], 32'h100);
        chk("split_be1", log_be[1], 4'h3);

        run_txn(1'b0, 32'h200, 32'h0, 2'd3, 1'b1, 5'd12, 0, 1, r);

        @(negedge clk);
        ns_req_valid = 1'b1; ns_req_addr = 32'h0FE; ns_req_width = 2'd2; ns_req_rd = 5'd21;
        @(negedge clk);
        ns_req_valid = 1'b0;
        chk("ns_rsp_valid", ns_rsp_valid, 1);
        chk("ns_rsp_err", ns_rsp_err, 1);
        chk("ns_rsp_rd", ns_rsp_rd, 21);
        chk("ns_rsp_rdata", ns_rsp_rdata, 0);
        chk("ns_no_bus", ns_bus_valid, 0);
        @(negedge clk);
        chk("ns_pulse", ns_rsp_valid, 0);
        chk("ns_ready", ns_req_ready, 1);
        chk("ns_no_bus2", ns_bus_valid, 0);

        set_word(32'h100, 32'h0BADF00D);
        r_delay = 0; v_delay = 6;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h100; req_width = 2'd2;
        req_signext = 1'b0; req_rd = 5'd5;
        @(negedge clk);
        req_valid = 1'b0;
        chk("rr_bus_valid", bus_valid, 1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rr_ready", req_ready, 1);
        chk("rr_outs", {rsp_valid, rsp_rdata, rsp_rd, rsp_err, bus_valid, bus_we, bus_addr, bus_wdata, bus_be}, 0);
        @(negedge clk);
        reset = 1'b0;
        hits = 0;
        repeat (10) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || bus_valid !== 1'b0 || req_ready !== 1'b1) hits++;
        end
        chk("rr_late_rvalid_ignored", hits, 0);
        run_txn(1'b0, 32'h100, 32'h0, 2'd2, 1'b0, 5'd6, 0, 1, r);
        chk("rr_after_lw", r, 32'h0BADF00D);

        for (int t = 0; t < 60; t++) begin
            if ($urandom_range(0, 7) == 0) a = 32'hFFFFFFF8 + 32'($urandom_range(0, 7));
            else a = 32'h200 + 32'($urandom_range(0, 255));
            w  = 2'($urandom_range(0, 2));
            wd = $urandom;
            run_txn(1'($urandom_range(0, 1)), a, wd, w, 1'($urandom_range(0, 1)),
                    5'($urandom_range(0, 31)), int'($urandom_range(0, 2)),
                    int'($urandom_range(1, 3)), r);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cpu7_lsu.md
Name: cpu7_lsu

Overview:
Parametrised load/store unit for the next-generation core. It replaces the fixed-width MEM-stage load extraction with a sequential block. The block generates byte enables and aligns store data, and it extracts, sign-extends or zero-extends load data for B/H/W/D widths. Misaligned accesses are either split into two bus beats or trapped. It sits between the EX/MEM pipeline register and the data-memory bus, and it returns the result and destination index to the writeback path.

Parameters:
XLEN, 32, data and address width; legal values are 32 or 64.
NB, XLEN/8, bytes per bus word; derived, not overridable.
SPLIT_MISALIGNED, 1, 1 = split line-crossing accesses into two beats; 0 = report an error with no bus traffic.
RFIDX_W, 5, register index width.

Ports:
clk  in  1  core clock, rising edge
reset  in  1  asynchronous, active-high
req_valid  in  1  request present
req_ready  out  1  unit can accept a request
req_we  in  1  1 = store, 0 = load
req_addr  in  XLEN  byte address
req_wdata  in  XLEN  store data, right-justified
req_width  in  2  00 = B, 01 = H, 10 = W, 11 = D
req_signext  in  1  load sign-extend
req_rd  in  RFIDX_W  destination register index
rsp_valid  out  1  one-cycle completion pulse
rsp_rdata  out  XLEN  extended load result; 0 for stores and errors
rsp_rd  out  RFIDX_W  echoed req_rd
rsp_err  out  1  misaligned (split disabled) or illegal width
bus_valid  out  1  bus request
bus_ready  in  1  bus accepts request
bus_we  out  1  write
bus_addr  out  XLEN  word-aligned address (low log2(NB) bits are 0)
bus_wdata  out  XLEN  rotated store data
bus_be  out  NB  byte enables
bus_rvalid  in  1  completion for an accepted beat (reads and writes)
bus_rdata  in  XLEN  read word, valid with bus_rvalid

Behaviour:
- Reset values: all outputs are 0 except req_ready = 1. FSM state is IDLE and internal registers are cleared.
- Reset mid-operation returns the FSM to IDLE immediately. Any bus_rvalid arriving after reset deasserts is ignored while in IDLE.
- FSM states: IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP.
- IDLE: req_ready = 1. On req_valid, the unit latches all req_* fields, computes off = addr mod NB and size = 1 << width, then transitions:
  - width = D with XLEN = 32 -> RESP with err = 1.
  - off + size > NB and SPLIT_MISALIGNED = 0 -> RESP with err = 1.
  - otherwise -> REQ0.
- req_ready = 0 in every state except IDLE. At most one request is in flight.
- REQ0: bus_valid = 1, bus_addr = addr with low bits cleared, bus_be = bytes off .. min(off+size, NB)-1. bus_valid and all bus_* fields stay stable until bus_ready = 1, then -> WAIT0.
- WAIT0: on bus_rvalid, capture bus_rdata into beat0, then -> REQ1 if the access crosses the word boundary, otherwise -> RESP. bus_rvalid in the same cycle as acceptance is not allowed; the earliest is the next cycle.
- REQ1 / WAIT1: same rules as REQ0 / WAIT0, with bus_addr = aligned addr + NB (wraps modulo 2^XLEN) and bus_be = bytes 0 .. off+size-NB-1. Beat 1 data is captured into beat1.
- bus_wdata = req_wdata rotated left by 8*off bits. The same word is driven on both beats; bus_be selects the bytes.
- Load assembly: raw = ({beat1, beat0} >> 8*off)[XLEN-1:0], where beat1 = 0 when there is no split. raw is masked to size bytes, then sign-extended from bit 8*size-1 if req_signext, otherwise zero-extended. W on XLEN = 64 extends to 64; D is a pass-through.
- RESP: rsp_valid = 1 for exactly one cycle, with rsp_rd, rsp_rdata and rsp_err valid in that cycle; then -> IDLE.
  - Latency, aligned access with bus_ready and bus_rvalid both back-to-back: accept cycle N, bus_valid in N+1, rvalid in N+2, rsp_valid in N+3.
  - Error latency: rsp_valid in N+1 with no bus activity.
- rsp_* is 0 whenever rsp_valid = 0.

Test Plan:
- XLEN=32 aligned LW at 0x100, bus_rdata = 0xDEADBEEF -> bus_addr 0x100, bus_be 0xF, rsp_rdata 0xDEADBEEF, rsp_rd echoed, rsp_err 0; rsp_valid 3 cycles after accept with a zero-wait bus.
- LB at 0x103, bus_rdata = 0x80112233 -> bus_be 0x8, rsp_rdata 0xFFFFFF80; the same access as LBU -> 0x00000080.
- SH at 0x102, wdata 0x1234ABCD -> bus_addr 0x100, bus_be 0xC, bus_wdata 0xABCD1234; single beat; rsp_rdata 0. Also hold bus_ready low for 3 cycles and check that bus_* stays stable.
- SPLIT=1, LW at 0x0FE -> beat0 at addr 0x0FC, be 0xC, rdata 0x55661122; beat1 at addr 0x100, be 0x3, rdata 0x00003344 -> rsp_rdata 0x33445566.
- SPLIT=0, LW at 0x0FE -> no bus_valid, rsp_err = 1 one cycle after accept. Separately, XLEN=32 width D -> rsp_err = 1.
- Assert reset during WAIT0, then send a late bus_rvalid after release -> all outputs 0, req_ready 1, no rsp_valid; a following aligned LW completes correctly.
